// File: rtl/toy_trap_ctrl.sv
// Machine-mode trap/return controller: M-CSRs, fetch redirect and a RUN/WFI state machine.
// Optional debug mode (dpc, debug_mode, halt/dret handling) is enabled by TOY_TRAP_DEBUG_EN.
package toy_pack;
  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam logic [31:0] DEBUG_HALT_REQ = 32'h0000_0018;
endpackage

module toy_trap_ctrl #(
  parameter int          ADDR_WIDTH  = toy_pack::ADDR_WIDTH,
  parameter int          INST_WIDTH  = toy_pack::INST_WIDTH,
  parameter logic [31:0] RESET_MTVEC = 32'h0,
  parameter logic [31:0] DEBUG_ENTRY = 32'h800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_vld,
  input  logic [1:0]            jump_op,
  input  logic [31:0]           trap_cause,
  input  logic [ADDR_WIDTH-1:0] trap_pc,
  input  logic [INST_WIDTH-1:0] trap_inst,
  input  logic                  wfi_vld,
  input  logic                  irq_pending,
  input  logic                  csr_wr_en,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  redirect_vld,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  stall,
  output logic                  mstatus_mie
);
  localparam logic [1:0]  OP_SRET = 2'b00, OP_MRET = 2'b01, OP_DRET = 2'b10, OP_TRAP = 2'b11;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MTVEC = 12'h305, A_MEPC = 12'h341,
                          A_MCAUSE  = 12'h342, A_MTVAL = 12'h343, A_DPC  = 12'h7B1;

  typedef enum logic {S_RUN, S_WFI} state_t;

  state_t      state;
  logic [31:0] mtvec, mepc, mcause, mtval;
  logic        mie, mpie;
  logic [31:0] pc32, inst32, cause_eff, mtval_eff;
  logic        is_trap, is_mret, is_dret, m_trap;
  logic [ADDR_WIDTH-1:0] target;

  assign pc32   = 32'(trap_pc);
  assign inst32 = 32'(trap_inst);

`ifdef TOY_TRAP_DEBUG_EN
  logic [31:0] dpc;
  logic        debug_mode;
  logic        halt, dbg_trap;
`endif

  // Decode the request; sret (and dret without debug support) become illegal-instruction traps.
  always_comb begin
    is_trap   = 1'b0;
    is_mret   = 1'b0;
    is_dret   = 1'b0;
    cause_eff = 32'd2;
    case (jump_op)
      OP_TRAP: begin is_trap = 1'b1; cause_eff = trap_cause; end
      OP_MRET: is_mret = 1'b1;
      OP_SRET: is_trap = 1'b1;
`ifdef TOY_TRAP_DEBUG_EN
      OP_DRET: is_dret = 1'b1;
`else
      OP_DRET: is_trap = 1'b1;
`endif
      default: is_trap = 1'b1;
    endcase
    if (cause_eff == 32'd2)      mtval_eff = inst32;
    else if (cause_eff == 32'd3) mtval_eff = pc32;
    else                         mtval_eff = 32'd0;
    m_trap = is_trap;
    target = ADDR_WIDTH'(mtvec);
    if (is_mret) target = ADDR_WIDTH'(mepc);
`ifdef TOY_TRAP_DEBUG_EN
    halt     = is_trap && !debug_mode && (jump_op == OP_TRAP) && (trap_cause == toy_pack::DEBUG_HALT_REQ);
    dbg_trap = is_trap && (debug_mode || halt);
    m_trap   = is_trap && !dbg_trap;
    if (dbg_trap) target = ADDR_WIDTH'(DEBUG_ENTRY);
    if (is_dret)  target = ADDR_WIDTH'(dpc);
`endif
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      A_MSTATUS: csr_rdata = {24'd0, mpie, 3'd0, mie, 3'd0};
      A_MTVEC:   csr_rdata = mtvec;
      A_MEPC:    csr_rdata = mepc;
      A_MCAUSE:  csr_rdata = mcause;
      A_MTVAL:   csr_rdata = mtval;
`ifdef TOY_TRAP_DEBUG_EN
      A_DPC:     csr_rdata = dpc;
`endif
      default:   csr_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      mtvec        <= {RESET_MTVEC[31:2], 2'b00};
      mepc         <= 32'd0;
      mcause       <= 32'd0;
      mtval        <= 32'd0;
      mie          <= 1'b0;
      mpie         <= 1'b0;
      redirect_vld <= 1'b0;
      redirect_pc  <= '0;
`ifdef TOY_TRAP_DEBUG_EN
      dpc          <= 32'd0;
      debug_mode   <= 1'b0;
`endif
    end else begin
      redirect_vld <= jump_vld;
      if (jump_vld) redirect_pc <= target;

      // CSR writes land first so a same-cycle trap/return overrides the registers it owns.
      if (csr_wr_en) begin
        case (csr_addr)
          A_MSTATUS: begin mie <= csr_wdata[3]; mpie <= csr_wdata[7]; end
          A_MTVEC:   mtvec  <= {csr_wdata[31:2], 2'b00};
          A_MEPC:    mepc   <= {csr_wdata[31:2], 2'b00};
          A_MCAUSE:  mcause <= csr_wdata;
          A_MTVAL:   mtval  <= csr_wdata;
`ifdef TOY_TRAP_DEBUG_EN
          A_DPC:     dpc    <= csr_wdata;
`endif
          default: ;
        endcase
      end

      if (jump_vld) begin
        if (m_trap) begin
          mepc   <= {pc32[31:2], 2'b00};
          mcause <= cause_eff;
          mtval  <= mtval_eff;
          mpie   <= mie;
          mie    <= 1'b0;
        end else if (is_mret) begin
          mie  <= mpie;
          mpie <= 1'b1;
        end
`ifdef TOY_TRAP_DEBUG_EN
        if (halt) begin
          dpc        <= pc32;
          debug_mode <= 1'b1;
        end
        if (is_dret) debug_mode <= 1'b0;
`endif
      end

      if (jump_vld) state <= S_RUN;
      else begin
        case (state)
          S_RUN:   if (wfi_vld && !irq_pending) state <= S_WFI;
          S_WFI:   if (irq_pending) state <= S_RUN;
          default: state <= S_RUN;
        endcase
      end
    end
  end

  // Wake-up is visible in the same cycle irq_pending rises.
  assign stall       = (state == S_WFI) && !irq_pending;
  assign mstatus_mie = mie;

endmodule
